clz_sequencer: RTL and testbench
================================

Name: clz_sequencer

Overview:
- Iterative count-leading-zeros controller for operands wider than 32 bits.
- Feeds one 32-bit word per cycle, MSB word first, into a shared combinational 32-bit CLZ core.
- Accumulates the count and terminates early on the first non-zero word.
- Sits between the integer unit's issue stage (valid/ready in) and writeback (valid/ready out).

Parameters:
DATA_WIDTH, 64, operand width; must be a multiple of 32 and at least 32.
WORDS, DATA_WIDTH/32, derived; number of 32-bit words scanned (localparam).
CNT_WIDTH, $clog2(DATA_WIDTH)+1, derived; count width, must hold the value DATA_WIDTH (localparam).

Ports:
clk_i  input  1  single system clock; all state updates on rising edge.
rst_n_i  input  1  reset, synchronous, active-low.
operand_i  input  DATA_WIDTH  operand to scan; sampled only on accept.
valid_i  input  1  operand valid.
ready_o  output  1  sequencer can accept an operand this cycle.
count_o  output  CNT_WIDTH  number of leading zeros; equals DATA_WIDTH when operand is 0.
is_zero_o  output  1  operand was entirely zero.
valid_o  output  1  result valid; held until consumed.
ready_i  input  1  downstream consumes the result.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - State goes to IDLE; count_o, is_zero_o and valid_o go to 0; internal shift register, word counter and accumulator clear.
  - valid_i is ignored while rst_n_i is low.
  - A reset in any state, including mid-SCAN, aborts the operation and no result is produced.
- FSM states:
  - IDLE: ready_o=1, valid_o=0. On valid_i: latch operand_i into the shift register, clear accumulator and word counter, go to SCAN.
  - SCAN: ready_o=0. The top 32 bits of the shift register drive clz_word32.
    - Word non-zero: accumulator += word_count (0..31); go to DONE; is_zero=0.
    - Word zero and word counter == WORDS-1: accumulator += 32 (total = DATA_WIDTH); is_zero=1; go to DONE.
    - Word zero otherwise: accumulator += 32; shift register shifts left by 32 (zero fill); word counter +1; stay in SCAN.
  - DONE: valid_o=1; count_o and is_zero_o are registered and stable.
    - ready_i=1 and valid_i=1: result consumed and new operand accepted in the same cycle; go to SCAN.
    - ready_i=1 and valid_i=0: go to IDLE.
    - ready_i=0: hold all outputs unchanged.
- ready_o = (state==IDLE) | (state==DONE & ready_i). This is combinational from state and ready_i; there is no combinational path from valid_i.
- Latency (accept edge = cycle 0):
  - First non-zero word is word k (0 = MSB word): valid_o rises at cycle k+2.
  - All-zero operand: valid_o rises at cycle WORDS+1.
- Throughput: one result per (k+2) cycles with back-to-back accept from DONE.
- Arithmetic:
  - Accumulator is CNT_WIDTH bits and cannot overflow; maximum value is DATA_WIDTH.
  - Word counter is $clog2(WORDS) bits, minimum 1.
- count_o and is_zero_o update only on the SCAN->DONE transition.
- Outputs are don't-care-free: they retain the last result through IDLE until the next result is loaded.

Decomposition:
- Package clz_pkg contains:
  - WORD_WIDTH=32 and NIBBLES=8.
  - typedef enum logic [1:0] clz_state_t {IDLE, SCAN, DONE}.
- Sub-module clz_word32 (combinational):
  - Inputs and outputs: word_i[31:0] -> word_count_o[4:0], word_is_zero_o.
  - Per-nibble zero flags feed a boundary nibble encoder, which gives count bits [4:2].
  - An in-nibble 2-bit priority count of the first non-zero nibble, selected by that encoding, gives bits [1:0].
- clz_sequencer holds the FSM, shift register, word counter, accumulator and output registers.

Test Plan:
- DATA_WIDTH=64, operand 0x8000_0000_0000_0000 -> count_o=0, is_zero_o=0, valid_o at cycle 2.
- Operand 0x0000_0000_0000_0001 -> count_o=63, valid_o at cycle 3.
- Operand 0x0 -> count_o=64, is_zero_o=1, valid_o at cycle 3.
- Backpressure and back-to-back:
  - Operand 0x0000_0000_00F0_0000 -> count_o=40.
  - Hold ready_i=0 for 5 cycles -> outputs stable and ready_o=0 throughout.
  - Then ready_i=1 with valid_i=1 and operand 0x0001_0000_0000_0000 -> accepted that cycle; next result count_o=15 at cycle 2.
- Reset mid-operation:
  - Accept 0x0, drive rst_n_i=0 on cycle 1 -> valid_o=0, count_o=0, ready_o=1 after release, no stale result.
  - Next operand 0x0000_0000_8000_0000 -> count_o=32.
- DATA_WIDTH=32, operand 0x0000_1000 -> count_o=19, valid_o at cycle 2; operand 0 -> count_o=32, is_zero_o=1.

Source files
------------

// File: rtl/clz_pkg.sv
// Shared types and constants for the iterative count-leading-zeros sequencer.
package clz_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int NIBBLES    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } clz_state_t;

endpackage

// File: rtl/clz_word32.sv
// Combinational 32-bit count-leading-zeros core built from nibble zero flags.
module clz_word32
  import clz_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic [4:0]            word_count_o,
  output logic                  word_is_zero_o
);

  logic [3:0]         nib [NIBBLES];
  logic [NIBBLES-1:0] nib_zero;
  logic [2:0]         nib_sel;
  logic [3:0]         sel_nib;
  logic [1:0]         in_nib;

  // Nibble 0 is the most significant nibble of the word.
  always_comb begin
    for (int i = 0; i < NIBBLES; i++) begin
      nib[i]      = word_i[WORD_WIDTH-1-4*i -: 4];
      nib_zero[i] = (nib[i] == 4'h0);
    end
  end

  // Index of the first non-zero nibble; an all-zero word selects the last one.
  always_comb begin
    nib_sel = 3'(NIBBLES - 1);
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      if (!nib_zero[i]) nib_sel = 3'(i);
    end
  end

  assign sel_nib = nib[nib_sel];

  always_comb begin
    in_nib = 2'd3;
    if (sel_nib[3])      in_nib = 2'd0;
    else if (sel_nib[2]) in_nib = 2'd1;
    else if (sel_nib[1]) in_nib = 2'd2;
  end

  assign word_count_o   = {nib_sel, in_nib};
  assign word_is_zero_o = &nib_zero;

endmodule

// File: rtl/clz_sequencer.sv
// Wide-operand count-leading-zeros: scans one 32-bit word per cycle, MSB word
// first, and stops on the first non-zero word.
module clz_sequencer
  import clz_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(DATA_WIDTH):0]   count_o,
  output logic                          is_zero_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  localparam int WORDS      = DATA_WIDTH / WORD_WIDTH;
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1;
  localparam int WCNT_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;

  clz_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [WCNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   is_zero_q, is_zero_d;

  logic [WORD_WIDTH-1:0]  top_word;
  logic [4:0]             word_count;
  logic                   word_is_zero;
  logic                   accept;
  logic                   last_word;

  assign top_word = shift_q[DATA_WIDTH-1 -: WORD_WIDTH];

  clz_word32 u_clz_word32 (
    .word_i         (top_word),
    .word_count_o   (word_count),
    .word_is_zero_o (word_is_zero)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. ready_o depends only on state and ready_i (never on valid_i), and
  // valid_o with its payload is held unchanged until ready_i is seen high.
  assign ready_o   = (state_q == IDLE) | ((state_q == DONE) & ready_i);
  assign accept    = valid_i & ready_o;
  assign last_word = (wcnt_q == WCNT_WIDTH'(WORDS - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    count_d   = count_q;
    is_zero_d = is_zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SCAN;
          shift_d = operand_i;
          wcnt_d  = '0;
          acc_d   = '0;
        end
      end
      SCAN: begin
        if (!word_is_zero) begin
          acc_d     = acc_q + CNT_WIDTH'(word_count);
          count_d   = acc_d;
          is_zero_d = 1'b0;
          state_d   = DONE;
        end else begin
          acc_d = acc_q + CNT_WIDTH'(WORD_WIDTH);
          if (last_word) begin
            count_d   = acc_d;
            is_zero_d = 1'b1;
            state_d   = DONE;
          end else begin
            shift_d = shift_q << WORD_WIDTH;
            wcnt_d  = wcnt_q + WCNT_WIDTH'(1);
          end
        end
      end
      DONE: begin
        // The result register is left alone here so it survives into IDLE/SCAN.
        if (ready_i) begin
          if (valid_i) begin
            state_d = SCAN;
            shift_d = operand_i;
            wcnt_d  = '0;
            acc_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      wcnt_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      is_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign valid_o   = (state_q == DONE);
  assign count_o   = count_q;
  assign is_zero_o = is_zero_q;

endmodule

// File: tb/tb_clz_sequencer.sv
// Self-checking bench for clz_sequencer: 64-bit instance checked every cycle
// against a latency-level model, plus a 32-bit instance with directed checks.
module tb_clz_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid_i, ready_i;
  logic [63:0] operand;
  logic        ready_o, is_zero_o, valid_o;
  logic [6:0]  count_o;

  logic        rst32_n, valid32_i, ready32_i;
  logic [31:0] operand32;
  logic        ready32_o, is_zero32_o, valid32_o;
  logic [5:0]  count32_o;

  clz_sequencer #(.DATA_WIDTH(64)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .operand_i (operand),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .count_o   (count_o),
    .is_zero_o (is_zero_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  clz_sequencer #(.DATA_WIDTH(32)) dut32 (
    .clk_i     (clk),
    .rst_n_i   (rst32_n),
    .operand_i (operand32),
    .valid_i   (valid32_i),
    .ready_o   (ready32_o),
    .count_o   (count32_o),
    .is_zero_o (is_zero32_o),
    .valid_o   (valid32_o),
    .ready_i   (ready32_i)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan bits from the MSB down.
  function automatic int ref_lz(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return w - 1 - i;
    end
    return w;
  endfunction

  // Cycles from accept (cycle 0) to the first cycle valid_o is high.
  function automatic int ref_lat(input int lz, input int w);
    if (lz == w) return w / 32 + 1;
    return lz / 32 + 2;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0:       v = {$urandom, $urandom};
      1:       v = {32'h0, $urandom};
      2:       v = 64'h1 << $urandom_range(0, 63);
      3:       v = 64'h0;
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  // ---------------- behavioural model (64-bit instance) ----------------
  logic [7:0] exp_q[$];   // {is_zero, count} of results still being computed
  int         busy = 0;   // edges left until the pending result appears
  logic       m_valid = 1'b0;
  logic [6:0] m_count = '0;
  logic       m_zero  = 1'b0;
  bit         chk_en  = 1'b0;
  int         m_lz;
  logic [7:0] m_res;
  bit         m_acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_count = '0;
      m_zero  = 1'b0;
      busy    = 0;
      exp_q.delete();
    end else begin
      m_acc = valid_i && (busy == 0) && (!m_valid || ready_i);
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          m_res   = exp_q.pop_front();
          m_valid = 1'b1;
          m_count = m_res[6:0];
          m_zero  = m_res[7];
        end
      end else begin
        if (m_valid && ready_i) m_valid = 1'b0;
        if (m_acc) begin
          m_lz = ref_lz(operand, 64);
          exp_q.push_back({(m_lz == 64), 7'(m_lz)});
          busy = ref_lat(m_lz, 64) - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o",   ready_o,   (busy == 0) && (!m_valid || ready_i));
      check("valid_o",   valid_o,   m_valid);
      check("count_o",   count_o,   m_count);
      check("is_zero_o", is_zero_o, m_zero);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic directed(input string name, input logic [63:0] op, input int exp_cnt,
                          input bit exp_z, input int exp_lat);
    int lat;
    int guard;
    guard   = 0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    operand = op;
    #1;
    while (!ready_o && guard < 40) begin
      tick();
      guard++;
    end
    tick();
    valid_i = 1'b0;
    operand = rand_op();
    wait_valid(lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " count"}, count_o, exp_cnt);
    check({name, " is_zero"}, is_zero_o, exp_z);
  endtask

  task automatic directed32(input string name, input logic [31:0] op, input int exp_cnt,
                            input bit exp_z, input int exp_lat);
    int lat;
    int guard;
    guard     = 0;
    ready32_i = 1'b1;
    valid32_i = 1'b1;
    operand32 = op;
    #1;
    while (!ready32_o && guard < 40) begin
      tick();
      guard++;
    end
    tick();
    valid32_i = 1'b0;
    operand32 = $urandom;
    lat = 1;
    while (!valid32_o && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " count"}, count32_o, exp_cnt);
    check({name, " is_zero"}, is_zero32_o, exp_z);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [31:0] r32;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; operand = '0;
    rst32_n = 1'b0; valid32_i = 1'b0; ready32_i = 1'b1; operand32 = '0;
    repeat (3) tick();
    check("reset valid_o", valid_o, 1'b0);
    check("reset count_o", count_o, 7'd0);
    check("reset is_zero_o", is_zero_o, 1'b0);
    check("reset ready_o", ready_o, 1'b1);
    chk_en  = 1'b1;
    rst_n   = 1'b1;
    rst32_n = 1'b1;

    // Pin the reference model with hand-computed values.
    check("model msb", ref_lz(64'h8000_0000_0000_0000, 64), 0);
    check("model lsb", ref_lz(64'h1, 64), 63);
    check("model zero", ref_lz(64'h0, 64), 64);
    check("model f0", ref_lz(64'h0000_0000_00F0_0000, 64), 40);
    check("model lat zero", ref_lat(64, 64), 3);

    directed("msb", 64'h8000_0000_0000_0000, 0, 1'b0, 2);
    directed("lsb", 64'h0000_0000_0000_0001, 63, 1'b0, 3);
    directed("zero", 64'h0, 64, 1'b1, 3);
    tick();

    // Backpressure, then consume-and-accept in one cycle.
    ready_i = 1'b0; valid_i = 1'b1; operand = 64'h0000_0000_00F0_0000;
    tick();
    valid_i = 1'b0;
    wait_valid(lat);
    check("bp latency", lat, 3);
    check("bp count", count_o, 7'd40);
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", valid_o, 1'b1);
      check("bp hold count", count_o, 7'd40);
      check("bp hold is_zero", is_zero_o, 1'b0);
      check("bp hold ready", ready_o, 1'b0);
      tick();
    end
    ready_i = 1'b1; valid_i = 1'b1; operand = 64'h0001_0000_0000_0000;
    #1;
    check("b2b ready", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
    wait_valid(lat);
    check("b2b latency", lat, 2);
    check("b2b count", count_o, 7'd15);
    tick();

    // Reset in the middle of a scan discards the operation.
    valid_i = 1'b1; operand = 64'h0; ready_i = 1'b1;
    tick();
    valid_i = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("abort valid_o", valid_o, 1'b0);
    check("abort count_o", count_o, 7'd0);
    check("abort ready_o", ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort no stale", valid_o, 1'b0);
    end
    directed("post_rst", 64'h0000_0000_8000_0000, 32, 1'b0, 3);
    tick();

    // Random traffic with backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      valid_i = ($urandom_range(0, 1) == 1);
      ready_i = ($urandom_range(0, 9) < 7);
      operand = rand_op();
      rst_n   = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    repeat (6) tick();

    // Single-word configuration.
    directed32("w32 1000", 32'h0000_1000, 19, 1'b0, 2);
    directed32("w32 zero", 32'h0, 32, 1'b1, 2);
    for (int i = 0; i < 100; i++) begin
      r32 = rand_op() >> 32;
      directed32("w32 rand", r32, ref_lz({32'h0, r32}, 32), (r32 == 32'h0), 2);
    end

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
